// File: rtl/div16by8_seq_if.sv
// rtl/div16by8_seq_if.sv - start/done handshake bundle for the 16/8 divider
//
// Purpose: groups the request and result signals of div16by8_seq.
// Signals:
//   start        request a division (sampled only when the divider is idle)
//   dividend     16-bit numerator, captured on the accepting edge
//   divisor      8-bit denominator, captured on the accepting edge
//   busy         high while the shift-and-subtract loop is running
//   done         one-cycle pulse when quotient/remainder become valid
//   quotient     16-bit result quotient
//   remainder    8-bit result remainder
//   div_by_zero  set together with done when the captured divisor was 0
// Modports: master drives requests, slave (the divider) drives results.

interface div16by8_seq_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div16by8_seq.sv
// rtl/div16by8_seq.sv - sequential 16/8 restoring divider, one quotient bit per clock
//
// Purpose: shift-and-subtract divider producing a 16-bit quotient and an
// 8-bit remainder, 16 iterations after the accepting edge.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset, aborts any division in flight
//   bus    div16by8_seq_if.slave: start/dividend/divisor in,
//          busy/done/quotient/remainder/div_by_zero out
// Build option:
//   DIV_SIGNED_EN  when defined, operands are two's complement (truncating
//                  division); when undefined the divider is purely unsigned.

module div16by8_seq #(
  parameter int ITER = 16
) (
  input logic            clk,
  input logic            rst_n,
  div16by8_seq_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

  logic [1:0]  state_q,     state_d;
  logic [3:0]  count_q,     count_d;
  logic [8:0]  p_q,         p_d;
  logic [15:0] shreg_q,     shreg_d;
  logic [7:0]  divisor_q,   divisor_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic [15:0] quotient_q,  quotient_d;
  logic [7:0]  remainder_q, remainder_d;
  logic        dbz_q,       dbz_d;

  // Operand magnitudes loaded into the unsigned core.
  logic [15:0] dvd_mag;
  logic [7:0]  dvs_mag;

  // One restoring step.
  logic [8:0]  p_shift;
  logic        p_ge;
  logic [8:0]  p_next;
  logic [15:0] q_next;

  // Results after optional sign fix-up.
  logic [15:0] q_fix;
  logic [7:0]  r_fix;

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;

  // -32768 and -128 have magnitudes 32768 and 128, which still fit the
  // unsigned operand widths, so no special case is needed.
  always_comb begin
    dvd_mag = bus.dividend[15] ? (~bus.dividend + 16'd1) : bus.dividend;
    dvs_mag = bus.divisor[7]   ? (~bus.divisor  + 8'd1)  : bus.divisor;
  end

  // Quotient is negative when signs differ; remainder follows the dividend.
  always_comb begin
    q_fix = neg_q_q ? (~q_next + 16'd1) : q_next;
    r_fix = neg_r_q ? (~p_next[7:0] + 8'd1) : p_next[7:0];
  end
`else
  always_comb begin
    dvd_mag = bus.dividend;
    dvs_mag = bus.divisor;
  end

  always_comb begin
    q_fix = q_next;
    r_fix = p_next[7:0];
  end
`endif

  // The dividend bits leave shreg at the top while quotient bits enter at
  // the bottom, so after the last step shreg holds the whole quotient.
  // P[8] is always 0 after a restoring step; folding it into the compare
  // keeps the step correct for the full 9-bit partial remainder.
  always_comb begin
    p_shift = {p_q[7:0], shreg_q[15]};
    p_ge    = p_q[8] | (p_shift >= {1'b0, divisor_q});
    p_next  = p_ge ? (p_shift - {1'b0, divisor_q}) : p_shift;
    q_next  = {shreg_q[14:0], p_ge};
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    p_d         = p_q;
    shreg_d     = shreg_q;
    divisor_d   = divisor_q;
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == 8'd0) begin
            // No iterations: results are fixed and ready after one edge.
            state_d     = ST_DONE;
            done_d      = 1'b1;
            dbz_d       = 1'b1;
            quotient_d  = 16'hFFFF;
            remainder_d = bus.dividend[7:0];
          end else begin
            state_d   = ST_CALC;
            busy_d    = 1'b1;
            shreg_d   = dvd_mag;
            divisor_d = dvs_mag;
            p_d       = 9'd0;
            count_d   = 4'd0;
`ifdef DIV_SIGNED_EN
            neg_q_d   = bus.dividend[15] ^ bus.divisor[7];
            neg_r_d   = bus.dividend[15];
`endif
          end
        end
      end

      ST_CALC: begin
        shreg_d = q_next;
        p_d     = p_next;
        count_d = count_q + 4'd1;
        if (count_q == CNT_LAST) begin
          // Outputs take the result of this final step directly, so they
          // only ever change together with the done pulse.
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = q_fix;
          remainder_d = r_fix;
          dbz_d       = 1'b0;
        end
      end

      ST_DONE: begin
        // start is not looked at here, so a request during DONE is dropped.
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= 4'd0;
      p_q         <= 9'd0;
      shreg_q     <= 16'd0;
      divisor_q   <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= 16'd0;
      remainder_q <= 8'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      p_q         <= p_d;
      shreg_q     <= shreg_d;
      divisor_q   <= divisor_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`endif

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16by8_seq.sv
// tb/tb_div16by8_seq.sv - self-checking bench for div16by8_seq

module tb_div16by8_seq;

  logic clk;
  logic rst_n;

  div16by8_seq_if bus();

  div16by8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  logic [15:0] got_q;
  logic [7:0]  got_r;
  logic        got_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic division on the operand values.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output logic z);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 16'(sa / sb);
      r  = 8'(sa % sb);
`else
      q  = a / b;
      r  = 8'(a % b);
`endif
      z = 1'b0;
    end
  endfunction

  task automatic do_div(input logic [15:0] a, input logic [7:0] b,
                        input bit poke_mid, input bit poke_done);
    int lat;
    int nbusy;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    model(a, b, eq, er, ez);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    lat   = 1;
    nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      bus.start = poke_mid && (lat == 3);
      if (bus.start) begin
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom_range(1, 255));
      end
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("latency", 32'(lat), (b == 8'd0) ? 32'd1 : 32'd17);
    chk("busy_cycles", 32'(nbusy), (b == 8'd0) ? 32'd0 : 32'd16);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("quotient", 32'(bus.quotient), 32'(eq));
    chk("remainder", 32'(bus.remainder), 32'(er));
    chk("div_by_zero", 32'(bus.div_by_zero), 32'(ez));
    got_q = bus.quotient;
    got_r = bus.remainder;
    got_z = bus.div_by_zero;
    if (poke_done) begin
      bus.start    = 1'b1;
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom_range(1, 255));
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    if (poke_done) begin
      @(negedge clk);
      chk("done_start_ignored", 32'(bus.busy), 32'd0);
      chk("hold_quotient", 32'(bus.quotient), 32'(eq));
      chk("hold_remainder", 32'(bus.remainder), 32'(er));
    end
  endtask

  initial begin
    int ndone;
    int last_idx;
    int npulses;
    logic [15:0] ra;
    logic [7:0]  rb;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;

    // Basic division
    do_div(16'd1000, 8'd7, 1'b0, 1'b0);
`ifndef DIV_SIGNED_EN
    chk("basic_q_const", 32'(got_q), 32'd142);
    chk("basic_r_const", 32'(got_r), 32'd6);
`endif

    // Reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_quotient", 32'(bus.quotient), 32'd0);
    chk("midrst_remainder", 32'(bus.remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    do_div(16'd1000, 8'd7, 1'b0, 1'b0);

    // Extremes
    do_div(16'd65535, 8'd1, 1'b0, 1'b0);
    do_div(16'd65535, 8'd255, 1'b0, 1'b0);
`ifndef DIV_SIGNED_EN
    chk("max_by_255_q", 32'(got_q), 32'd257);
`endif
    do_div(16'd5, 8'd9, 1'b0, 1'b0);

    // Divide by zero, then a normal division clears the flag
    do_div(16'h1234, 8'd0, 1'b0, 1'b0);
    chk("dbz_q_const", 32'(got_q), 32'hFFFF);
    chk("dbz_r_const", 32'(got_r), 32'h34);
    chk("dbz_flag_const", 32'(got_z), 32'd1);
    do_div(16'd100, 8'd3, 1'b0, 1'b0);
    chk("dbz_cleared", 32'(got_z), 32'd0);

    // Starts during CALC and DONE are ignored
    do_div(16'd1000, 8'd7, 1'b1, 1'b1);

`ifdef DIV_SIGNED_EN
    do_div(-16'sd1000, 8'd7, 1'b0, 1'b0);
    chk("s_neg_dvd_q", 32'(got_q), 32'hFF72);
    chk("s_neg_dvd_r", 32'(got_r), 32'hFA);
    do_div(16'd1000, -8'sd7, 1'b0, 1'b0);
    chk("s_neg_dvs_q", 32'(got_q), 32'hFF72);
    chk("s_neg_dvs_r", 32'(got_r), 32'h06);
    do_div(16'h8000, 8'hFF, 1'b0, 1'b0);
    chk("s_min_q", 32'(got_q), 32'h8000);
    chk("s_min_r", 32'(got_r), 32'h00);
    chk("s_min_flag", 32'(got_z), 32'd0);
`endif

    // start held high: one result every 18 clocks
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
    last_idx = -1;
    npulses  = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (last_idx >= 0) chk("b2b_period", 32'(i - last_idx), 32'd18);
        last_idx = i;
        npulses++;
      end
    end
    chk("b2b_pulses", 32'(npulses >= 3), 32'd1);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    // Random operands
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = (i % 10 == 0) ? 8'd0 : 8'($urandom);
      do_div(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
